cd_xfer_fifo: RTL and testbench

Parametrised, bidirectional data-transfer FIFO for the CD block. It carries sector and status data between the CD-side SH-1 bus (register strobes and DMA channel 1) and the A-bus host data port. It adds a configurable depth and width, a selectable transfer direction, programmable DMA burst requests, host wait-state generation, and sticky overflow/underflow flags. It replaces the fixed 8×16 one-directional transfer buffer in the CD interface.

---
 rtl/cd_xfer_fifo.sv | 161 ++++++++++++++++
 tb/tb_cd_xfer_fifo.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cd_xfer_fifo.sv
// Bidirectional CD<->host transfer FIFO with DMA burst requests and sticky OVF/UNF flags.
// Latency: status flags and SH_RDATA are registered (visible the cycle after the strobe); HOST_RDATA and HOST_WAIT_N are combinational.
// Backpressure: writes to a full FIFO drop the data and set OVF; reads from an empty FIFO set UNF; HOST_WAIT_N stalls the host.
module cd_xfer_fifo #(
    parameter int DW    = 16,
    parameter int AW    = 3,
    parameter int BURST = 4
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          EN,
    input  logic          DIR,
    input  logic          FLUSH,
    input  logic          SH_WR,
    input  logic [DW-1:0] SH_WDATA,
    input  logic          SH_RD,
    output logic [DW-1:0] SH_RDATA,
    input  logic          HOST_SEL,
    input  logic          HOST_RD,
    input  logic          HOST_WR,
    input  logic [DW-1:0] HOST_WDATA,
    output logic [DW-1:0] HOST_RDATA,
    output logic          HOST_WAIT_N,
    output logic          DREQ,
    output logic [AW:0]   LEVEL,
    output logic          EMPTY,
    output logic          FULL,
    output logic          OVF,
    output logic          UNF
);

    localparam int DEPTH = 1 << AW;
    localparam int LW    = AW + 1;
    localparam int CW    = $clog2(BURST + 1);

    typedef enum logic {
        S_IDLE,
        S_REQ
    } state_t;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [LW-1:0] level;
    state_t        state;
    logic [CW-1:0] burst_cnt;
    logic          dir_q;

    logic          wr_act;
    logic          rd_act;
    logic [DW-1:0] wr_dat;
    logic          rd_ok;
    logic          wr_ok;
    logic          sh_xfer;
    logic          arm;
    logic          dir_chg;

    assign wr_act  = EN & (DIR ? HOST_WR : SH_WR);
    assign rd_act  = EN & (DIR ? SH_RD : HOST_RD);
    assign wr_dat  = DIR ? HOST_WDATA : SH_WDATA;
    assign rd_ok   = rd_act & ~EMPTY;
    // A read in the same cycle frees a slot, so a write to a full FIFO still lands.
    assign wr_ok   = wr_act & (~FULL | rd_ok);
    assign sh_xfer = DIR ? rd_ok : wr_ok;
    assign dir_chg = DIR != dir_q;
    assign arm     = DIR ? (level >= LW'(BURST))
                         : ((LW'(DEPTH) - level) >= LW'(BURST));

    assign LEVEL       = level;
    assign EMPTY       = (level == '0);
    assign FULL        = (level == LW'(DEPTH));
    assign HOST_RDATA  = mem[rd_ptr];
    assign HOST_WAIT_N = ~(HOST_SEL & EN & (DIR ? FULL : EMPTY));

    // RAM is deliberately left uninitialised by reset and flush.
    always_ff @(posedge CLK) begin
        if (RST_N && !FLUSH && wr_ok) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            level    <= '0;
            OVF      <= 1'b0;
            UNF      <= 1'b0;
            SH_RDATA <= '0;
        end else if (FLUSH) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
            OVF    <= 1'b0;
            UNF    <= 1'b0;
        end else begin
            if (rd_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
                if (DIR) begin
                    SH_RDATA <= mem[rd_ptr];
                end
            end
            if (wr_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_act && EMPTY) begin
                UNF <= 1'b1;
            end
            if (wr_act && !wr_ok) begin
                OVF <= 1'b1;
            end
            case ({wr_ok, rd_ok})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= S_IDLE;
            burst_cnt <= '0;
            dir_q     <= 1'b0;
            DREQ      <= 1'b0;
        end else begin
            dir_q <= DIR;
            if (FLUSH || !EN || dir_chg) begin
                state     <= S_IDLE;
                burst_cnt <= '0;
                DREQ      <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (arm) begin
                            state <= S_REQ;
                            DREQ  <= 1'b1;
                        end
                    end
                    S_REQ: begin
                        if (sh_xfer) begin
                            if (burst_cnt == CW'(BURST - 1)) begin
                                state     <= S_IDLE;
                                burst_cnt <= '0;
                                DREQ      <= 1'b0;
                            end else begin
                                burst_cnt <= burst_cnt + CW'(1);
                            end
                        end
                    end
                    default: begin
                        state     <= S_IDLE;
                        burst_cnt <= '0;
                        DREQ      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cd_xfer_fifo.sv
// Bench for cd_xfer_fifo: queue-based reference model compared every cycle, plus directed scenarios with literal expectations.
module tb_cd_xfer_fifo;
    localparam int DW    = 16;
    localparam int AW    = 3;
    localparam int BURST = 4;
    localparam int DEPTH = 8;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          EN = 1'b0;
    logic          DIR = 1'b0;
    logic          FLUSH = 1'b0;
    logic          SH_WR = 1'b0;
    logic [DW-1:0] SH_WDATA = '0;
    logic          SH_RD = 1'b0;
    logic [DW-1:0] SH_RDATA;
    logic          HOST_SEL = 1'b0;
    logic          HOST_RD = 1'b0;
    logic          HOST_WR = 1'b0;
    logic [DW-1:0] HOST_WDATA = '0;
    logic [DW-1:0] HOST_RDATA;
    logic          HOST_WAIT_N;
    logic          DREQ;
    logic [AW:0]   LEVEL;
    logic          EMPTY;
    logic          FULL;
    logic          OVF;
    logic          UNF;

    cd_xfer_fifo #(.DW(DW), .AW(AW), .BURST(BURST)) dut (
        .CLK(CLK), .RST_N(RST_N), .EN(EN), .DIR(DIR), .FLUSH(FLUSH),
        .SH_WR(SH_WR), .SH_WDATA(SH_WDATA), .SH_RD(SH_RD), .SH_RDATA(SH_RDATA),
        .HOST_SEL(HOST_SEL), .HOST_RD(HOST_RD), .HOST_WR(HOST_WR),
        .HOST_WDATA(HOST_WDATA), .HOST_RDATA(HOST_RDATA), .HOST_WAIT_N(HOST_WAIT_N),
        .DREQ(DREQ), .LEVEL(LEVEL), .EMPTY(EMPTY), .FULL(FULL), .OVF(OVF), .UNF(UNF)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: contents as a queue, flags and DREQ from the transfer rules.
    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_shr;
    bit            m_ovf, m_unf, m_dreq, m_dir;
    int            m_bcnt;

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mq.delete();
            m_shr = '0; m_ovf = 0; m_unf = 0; m_dreq = 0; m_dir = 0; m_bcnt = 0;
        end else begin
            int n;
            bit wa, ra, rd_ok, wr_ok, shx;
            logic [DW-1:0] wd;
            n  = mq.size();
            wa = EN && (DIR ? HOST_WR : SH_WR);
            ra = EN && (DIR ? SH_RD : HOST_RD);
            wd = DIR ? HOST_WDATA : SH_WDATA;
            rd_ok = ra && (n > 0);
            wr_ok = wa && ((n < DEPTH) || rd_ok);
            shx   = DIR ? rd_ok : wr_ok;
            if (FLUSH) begin
                mq.delete();
                m_ovf = 0; m_unf = 0;
            end else begin
                if (ra && n == 0) m_unf = 1;
                if (wa && !wr_ok) m_ovf = 1;
                if (rd_ok) begin
                    logic [DW-1:0] v;
                    v = mq.pop_front();
                    if (DIR) m_shr = v;
                end
                if (wr_ok) mq.push_back(wd);
            end
            if (FLUSH || !EN || DIR != m_dir) begin
                m_dreq = 0; m_bcnt = 0;
            end else if (!m_dreq) begin
                m_dreq = DIR ? (n >= BURST) : ((DEPTH - n) >= BURST);
            end else if (shx) begin
                m_bcnt++;
                if (m_bcnt == BURST) begin
                    m_dreq = 0; m_bcnt = 0;
                end
            end
            m_dir = DIR;
        end
    end

    always @(negedge CLK) begin
        bit exp_wait_n;
        exp_wait_n = !(HOST_SEL && EN && (DIR ? (mq.size() == DEPTH) : (mq.size() == 0)));
        check("m_level", 32'(LEVEL), 32'(mq.size()));
        check("m_empty", 32'(EMPTY), 32'(mq.size() == 0));
        check("m_full", 32'(FULL), 32'(mq.size() == DEPTH));
        check("m_ovf", 32'(OVF), 32'(m_ovf));
        check("m_unf", 32'(UNF), 32'(m_unf));
        check("m_sh_rdata", 32'(SH_RDATA), 32'(m_shr));
        check("m_dreq", 32'(DREQ), 32'(m_dreq));
        check("m_host_wait_n", 32'(HOST_WAIT_N), 32'(exp_wait_n));
        if (mq.size() > 0) check("m_host_rdata", 32'(HOST_RDATA), 32'(mq[0]));
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clr();
        SH_WR = 0; SH_RD = 0; HOST_RD = 0; HOST_WR = 0; FLUSH = 0;
    endtask

    task automatic do_reset();
        clr();
        EN = 0; DIR = 0; HOST_SEL = 0;
        RST_N = 0;
        tick();
        tick();
        RST_N = 1;
    endtask

    initial begin
        int wp;
        do_reset();
        check("rst_level", 32'(LEVEL), 32'd0);
        check("rst_empty", 32'(EMPTY), 32'd1);
        check("rst_full", 32'(FULL), 32'd0);
        check("rst_dreq", 32'(DREQ), 32'd0);
        check("rst_ovf", 32'(OVF), 32'd0);
        check("rst_unf", 32'(UNF), 32'd0);
        check("rst_sh_rdata", 32'(SH_RDATA), 32'd0);
        check("rst_wait_n", 32'(HOST_WAIT_N), 32'd1);

        // CD->host burst
        EN = 1; DIR = 0;
        tick();
        check("b_dreq_rise", 32'(DREQ), 32'd1);
        for (int k = 1; k <= 4; k++) begin
            SH_WR = 1; SH_WDATA = 16'(k * 16'h1111);
            tick();
        end
        clr();
        check("b_dreq_fall", 32'(DREQ), 32'd0);
        check("b_level4", 32'(LEVEL), 32'd4);
        tick();
        check("b_dreq_rearm", 32'(DREQ), 32'd1);
        for (int k = 1; k <= 4; k++) begin
            check("b_host_rdata", 32'(HOST_RDATA), 32'(k * 16'h1111));
            HOST_RD = 1;
            tick();
        end
        clr();
        check("b_empty", 32'(EMPTY), 32'd1);

        // Host wait on empty
        do_reset();
        EN = 1; DIR = 0; HOST_SEL = 1;
        #1;
        check("w_wait_empty", 32'(HOST_WAIT_N), 32'd0);
        SH_WR = 1; SH_WDATA = 16'hABCD;
        tick();
        clr();
        check("w_wait_release", 32'(HOST_WAIT_N), 32'd1);
        check("w_host_rdata", 32'(HOST_RDATA), 32'h0000ABCD);
        HOST_SEL = 0;

        // Overflow, wrap and simultaneous access
        do_reset();
        EN = 1; DIR = 0;
        for (int i = 1; i <= 9; i++) begin
            SH_WR = 1; SH_WDATA = 16'(16'h0100 + i);
            tick();
        end
        clr();
        check("o_ovf", 32'(OVF), 32'd1);
        check("o_level8", 32'(LEVEL), 32'd8);
        check("o_full", 32'(FULL), 32'd1);
        HOST_RD = 1; SH_WR = 1; SH_WDATA = 16'h0099;
        tick();
        clr();
        check("o_level_simul", 32'(LEVEL), 32'd8);
        for (int k = 2; k <= 8; k++) begin
            check("o_order", 32'(HOST_RDATA), 32'(16'h0100 + k));
            HOST_RD = 1;
            tick();
        end
        clr();
        check("o_wrapped", 32'(HOST_RDATA), 32'h00000099);
        HOST_RD = 1;
        tick();
        clr();
        check("o_empty", 32'(EMPTY), 32'd1);

        // Host->CD
        do_reset();
        EN = 1; DIR = 1;
        for (int k = 1; k <= 4; k++) begin
            HOST_WR = 1; HOST_WDATA = 16'(k);
            tick();
        end
        clr();
        tick();
        check("h_dreq_rise", 32'(DREQ), 32'd1);
        for (int k = 1; k <= 4; k++) begin
            SH_RD = 1;
            tick();
            check("h_sh_rdata", 32'(SH_RDATA), 32'(k));
        end
        clr();
        check("h_dreq_fall", 32'(DREQ), 32'd0);
        SH_RD = 1;
        tick();
        clr();
        check("h_unf", 32'(UNF), 32'd1);
        check("h_sh_rdata_hold", 32'(SH_RDATA), 32'd4);

        // FLUSH priority
        do_reset();
        EN = 1; DIR = 0;
        HOST_RD = 1;
        tick();
        clr();
        check("f_unf_set", 32'(UNF), 32'd1);
        for (int k = 1; k <= 3; k++) begin
            SH_WR = 1; SH_WDATA = 16'(16'h0200 + k);
            tick();
        end
        clr();
        check("f_level3", 32'(LEVEL), 32'd3);
        check("f_dreq_on", 32'(DREQ), 32'd1);
        FLUSH = 1; SH_WR = 1; SH_WDATA = 16'h5555;
        tick();
        clr();
        check("f_level0", 32'(LEVEL), 32'd0);
        check("f_empty", 32'(EMPTY), 32'd1);
        check("f_dreq_off", 32'(DREQ), 32'd0);
        check("f_ovf", 32'(OVF), 32'd0);
        check("f_unf", 32'(UNF), 32'd0);

        // Async reset mid-burst
        do_reset();
        EN = 1; DIR = 1;
        for (int k = 1; k <= 4; k++) begin
            HOST_WR = 1; HOST_WDATA = 16'(k);
            tick();
        end
        clr();
        tick();
        SH_RD = 1;
        tick();
        clr();
        check("a_sh_rdata", 32'(SH_RDATA), 32'd1);
        check("a_dreq", 32'(DREQ), 32'd1);
        check("a_level", 32'(LEVEL), 32'd3);
        #2;
        RST_N = 0;
        #1;
        check("a_rst_level", 32'(LEVEL), 32'd0);
        check("a_rst_dreq", 32'(DREQ), 32'd0);
        check("a_rst_sh_rdata", 32'(SH_RDATA), 32'd0);
        check("a_rst_empty", 32'(EMPTY), 32'd1);
        tick();
        RST_N = 1;

        // Randomized traffic against the model
        EN = 1; DIR = 0;
        wp = 5;
        for (int c = 0; c < 4000; c++) begin
            if (c % 100 == 0) wp = int'($urandom_range(1, 9));
            EN       = ($urandom_range(0, 19) != 0);
            if ($urandom_range(0, 39) == 0) DIR = ~DIR;
            FLUSH    = ($urandom_range(0, 59) == 0);
            SH_WR    = (int'($urandom_range(0, 9)) < wp);
            HOST_WR  = (int'($urandom_range(0, 9)) < wp);
            SH_RD    = (int'($urandom_range(0, 9)) < 10 - wp);
            HOST_RD  = (int'($urandom_range(0, 9)) < 10 - wp);
            HOST_SEL = ($urandom_range(0, 1) == 1);
            SH_WDATA   = 16'($urandom);
            HOST_WDATA = 16'($urandom);
            tick();
        end
        clr();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
